// File: rtl/instr_loader.sv
// Instruction-store writer: parses framed host bytes into imem and label-table writes.
// Optional INSTR_LOADER_CHKSUM_EN adds a trailing mod-256 checksum byte after the data.
module instr_loader #(
    parameter int          ADDR_W   = 16,
    parameter int          MAX_LEN  = 256,
    parameter logic [7:0]  CMD_PROG = 8'hA5,
    parameter logic [7:0]  CMD_LBL  = 8'h5A
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              err_clr,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [7:0]        imem_wdata,
    output logic              lbl_we,
    output logic [1:0]        lbl_idx,
    output logic [15:0]       lbl_data,
    output logic              prog_loaded,
    output logic              cpu_start,
    output logic              err
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_LEN_H   = 4'd1;
    localparam logic [3:0] S_LEN_L   = 4'd2;
    localparam logic [3:0] S_DATA    = 4'd3;
`ifdef INSTR_LOADER_CHKSUM_EN
    localparam logic [3:0] S_CHK     = 4'd4;
`endif
    localparam logic [3:0] S_LBL_IDX = 4'd5;
    localparam logic [3:0] S_LBL_H   = 4'd6;
    localparam logic [3:0] S_LBL_L   = 4'd7;
    localparam logic [3:0] S_DONE_P  = 4'd8;
    localparam logic [3:0] S_ERR     = 4'd9;

    localparam logic [16:0] LP_MAX = 17'(MAX_LEN);

    logic [3:0]        r_state;
    logic [3:0]        w_state_nxt;
    logic [3:0]        w_fin;
    logic [7:0]        r_len_h;
    logic [15:0]       r_remain;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_imem_we;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [7:0]        r_imem_wdata;
    logic              r_lbl_we;
    logic [1:0]        r_lbl_idx;
    logic [15:0]       r_lbl_data;
    logic              r_loaded;
    logic              w_xfer;
    logic [15:0]       w_len;
    logic              w_len_ok;
    logic              w_last;

`ifdef INSTR_LOADER_CHKSUM_EN
    logic [7:0]        r_sum;
    assign w_fin = S_CHK;
`else
    assign w_fin = S_DONE_P;
`endif

    assign in_ready    = (r_state != S_ERR) && (r_state != S_DONE_P);
    assign err         = (r_state == S_ERR);
    assign cpu_start   = (r_state == S_DONE_P);
    assign w_xfer      = in_valid && in_ready;
    assign w_len       = {r_len_h, in_data};
    assign w_len_ok    = {1'b0, w_len} <= LP_MAX;
    assign w_last      = (r_remain == 16'd1);
    assign imem_we     = r_imem_we;
    assign imem_addr   = r_imem_addr;
    assign imem_wdata  = r_imem_wdata;
    assign lbl_we      = r_lbl_we;
    assign lbl_idx     = r_lbl_idx;
    assign lbl_data    = r_lbl_data;
    assign prog_loaded = r_loaded;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_xfer) begin
                if (in_data == CMD_PROG)     w_state_nxt = S_LEN_H;
                else if (in_data == CMD_LBL) w_state_nxt = S_LBL_IDX;
                else                         w_state_nxt = S_ERR;
            end
            S_LEN_H: if (w_xfer) w_state_nxt = S_LEN_L;
            S_LEN_L: if (w_xfer) begin
                if (!w_len_ok)          w_state_nxt = S_ERR;
                else if (w_len == 16'd0) w_state_nxt = w_fin;
                else                    w_state_nxt = S_DATA;
            end
            S_DATA: if (w_xfer && w_last) w_state_nxt = w_fin;
`ifdef INSTR_LOADER_CHKSUM_EN
            S_CHK: if (w_xfer) w_state_nxt = (in_data == r_sum) ? S_DONE_P : S_ERR;
`endif
            S_LBL_IDX: if (w_xfer) w_state_nxt = S_LBL_H;
            S_LBL_H:   if (w_xfer) w_state_nxt = S_LBL_L;
            S_LBL_L:   if (w_xfer) w_state_nxt = S_IDLE;
            S_DONE_P:  w_state_nxt = S_IDLE;
            S_ERR:     if (err_clr) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_len_h      <= 8'd0;
            r_remain     <= 16'd0;
            r_wr_addr    <= '0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= 8'd0;
            r_lbl_we     <= 1'b0;
            r_lbl_idx    <= 2'd0;
            r_lbl_data   <= 16'd0;
            r_loaded     <= 1'b0;
`ifdef INSTR_LOADER_CHKSUM_EN
            r_sum        <= 8'd0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_imem_we <= w_xfer && (r_state == S_DATA);
            r_lbl_we  <= w_xfer && (r_state == S_LBL_L);
            if (w_xfer && r_state == S_IDLE && in_data == CMD_PROG)
                r_loaded <= 1'b0;
            if (r_state == S_DONE_P)
                r_loaded <= 1'b1;
            if (w_xfer) begin
                unique case (r_state)
                    S_LEN_H: begin
                        r_len_h <= in_data;
`ifdef INSTR_LOADER_CHKSUM_EN
                        r_sum   <= 8'd0;
`endif
                    end
                    S_LEN_L: begin
                        r_remain  <= w_len;
                        r_wr_addr <= '0;
                    end
                    S_DATA: begin
                        r_imem_addr  <= r_wr_addr;
                        r_imem_wdata <= in_data;
                        r_wr_addr    <= r_wr_addr + ADDR_W'(1);
                        r_remain     <= r_remain - 16'd1;
`ifdef INSTR_LOADER_CHKSUM_EN
                        r_sum        <= r_sum + in_data;
`endif
                    end
                    S_LBL_IDX: r_lbl_idx <= in_data[1:0];
                    S_LBL_H:   r_lbl_data[15:8] <= in_data;
                    S_LBL_L:   r_lbl_data[7:0] <= in_data;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: per-cycle vector table plus multi-cycle load sequences.
// Works with or without INSTR_LOADER_CHKSUM_EN.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        err_clr;
    logic        imem_we;
    logic [15:0] imem_addr;
    logic [7:0]  imem_wdata;
    logic        lbl_we;
    logic [1:0]  lbl_idx;
    logic [15:0] lbl_data;
    logic        prog_loaded;
    logic        cpu_start;
    logic        err;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    int wa_q[$];
    int wd_q[$];
    int wc_q[$];
    int n_start = 0;
    logic [7:0] tx[$];

    instr_loader dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .err_clr(err_clr),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .lbl_we(lbl_we), .lbl_idx(lbl_idx), .lbl_data(lbl_data),
        .prog_loaded(prog_loaded), .cpu_start(cpu_start), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we) begin
            wa_q.push_back(int'(imem_addr));
            wd_q.push_back(int'(imem_wdata));
            wc_q.push_back(cyc);
        end
        if (cpu_start) n_start = n_start + 1;
    end

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        clr;
        logic        rdy;
        logic        lwe;
        logic [1:0]  idx;
        logic [15:0] lbl;
        logic        er;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(logic v, logic [7:0] d, logic clr, logic rdy,
                                logic lwe, logic [1:0] idx, logic [15:0] lbl,
                                logic er);
        vec_t t;
        t.v = v; t.d = d; t.clr = clr; t.rdy = rdy;
        t.lwe = lwe; t.idx = idx; t.lbl = lbl; t.er = er;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        n_start = 0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 20 && !done; k++) begin
            if (in_ready) done = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_byte: byte %0h not accepted within 20 cycles", b);
        end
    endtask

    task automatic send_all(input int gap_max);
        foreach (tx[i]) begin
            if (gap_max > 0) idle($urandom_range(gap_max, 0));
            send_byte(tx[i]);
        end
    endtask

    // Builds A5 len data.. and, when checksumming, appends sum + delta.
    task automatic build_prog(input logic [7:0] d[$], input logic [7:0] csum_delta);
        logic [7:0] s;
        s = 8'd0;
        tx.delete();
        tx.push_back(8'hA5);
        tx.push_back(8'h00);
        tx.push_back(8'(d.size()));
        foreach (d[i]) begin
            tx.push_back(d[i]);
            s = s + d[i];
        end
`ifdef INSTR_LOADER_CHKSUM_EN
        tx.push_back(s + csum_delta);
`else
        if (csum_delta != 8'd0) tx.push_back(8'h00);
`endif
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic check_writes(input string nm, input logic [7:0] d[$], input bit tight);
        chk({nm, " count"}, wa_q.size(), d.size());
        for (int i = 0; i < d.size() && i < wa_q.size(); i++) begin
            chk({nm, " addr"}, wa_q[i], i);
            chk({nm, " data"}, wd_q[i], d[i]);
            if (tight && i > 0) chk({nm, " gap"}, wc_q[i] - wc_q[i-1], 1);
        end
    endtask

    initial begin
        logic [7:0] p3[$];
        logic [7:0] p5[$];
        logic [7:0] p1[$];
        logic [7:0] p0[$];
        p3 = '{8'h4A, 8'h45, 8'h94};
        p5 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        p1 = '{8'h77};
        p0 = {};

        tbl[0]  = mk(1, 8'h5A, 0, 1, 0, 2'd0, 16'h0000, 0);
        tbl[1]  = mk(1, 8'hFD, 0, 1, 0, 2'd0, 16'h0000, 0);
        tbl[2]  = mk(1, 8'h12, 0, 1, 0, 2'd0, 16'h0000, 0);
        tbl[3]  = mk(1, 8'h34, 0, 1, 0, 2'd0, 16'h0000, 0);
        tbl[4]  = mk(0, 8'h00, 0, 1, 1, 2'd1, 16'h1234, 0);
        tbl[5]  = mk(1, 8'h3C, 0, 1, 0, 2'd0, 16'h0000, 0);
        tbl[6]  = mk(1, 8'hA5, 0, 0, 0, 2'd0, 16'h0000, 1);
        tbl[7]  = mk(0, 8'h00, 1, 0, 0, 2'd0, 16'h0000, 1);
        tbl[8]  = mk(1, 8'hA5, 1, 1, 0, 2'd0, 16'h0000, 0);
        tbl[9]  = mk(1, 8'h01, 0, 1, 0, 2'd0, 16'h0000, 0);
        tbl[10] = mk(1, 8'h01, 0, 1, 0, 2'd0, 16'h0000, 0);
        tbl[11] = mk(0, 8'h00, 0, 0, 0, 2'd0, 16'h0000, 1);
        tbl[12] = mk(0, 8'h00, 1, 0, 0, 2'd0, 16'h0000, 1);
        tbl[13] = mk(1, 8'h5A, 0, 1, 0, 2'd0, 16'h0000, 0);
        tbl[14] = mk(0, 8'h00, 0, 1, 0, 2'd0, 16'h0000, 0);
        tbl[15] = mk(1, 8'h02, 0, 1, 0, 2'd0, 16'h0000, 0);
        tbl[16] = mk(0, 8'h00, 0, 1, 0, 2'd0, 16'h0000, 0);
        tbl[17] = mk(1, 8'hAB, 0, 1, 0, 2'd0, 16'h0000, 0);
        tbl[18] = mk(1, 8'hCD, 0, 1, 0, 2'd0, 16'h0000, 0);
        tbl[19] = mk(0, 8'h00, 0, 1, 1, 2'd2, 16'hABCD, 0);

        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Per-cycle table: labels, bad command, oversize length, stalls
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("t%0d in_ready", i), in_ready, tbl[i].rdy);
            chk($sformatf("t%0d err", i), err, tbl[i].er);
            chk($sformatf("t%0d lbl_we", i), lbl_we, tbl[i].lwe);
            chk($sformatf("t%0d imem_we", i), imem_we, 0);
            chk($sformatf("t%0d cpu_start", i), cpu_start, 0);
            chk($sformatf("t%0d prog_loaded", i), prog_loaded, 0);
            if (tbl[i].lwe) begin
                chk($sformatf("t%0d lbl_idx", i), lbl_idx, tbl[i].idx);
                chk($sformatf("t%0d lbl_data", i), lbl_data, tbl[i].lbl);
            end
            in_valid = tbl[i].v;
            in_data  = tbl[i].d;
            err_clr  = tbl[i].clr;
            @(negedge clk);
        end
        in_valid = 1'b0; err_clr = 1'b0;
        idle(2);

        // Back-to-back program load
        clear_log();
        build_prog(p3, 8'd0);
        send_all(0);
        idle(3);
        check_writes("load3", p3, 1'b1);
        chk("load3 cpu_start count", n_start, 1);
        chk("load3 prog_loaded", prog_loaded, 1);

        // Label write leaves prog_loaded set
        tx = '{8'h5A, 8'h00, 8'h00, 8'h0A};
        send_all(0);
        chk("lbl lbl_we", lbl_we, 1);
        chk("lbl idx", lbl_idx, 0);
        chk("lbl data", lbl_data, 16'h000A);
        chk("lbl prog_loaded", prog_loaded, 1);
        idle(1);
        chk("lbl_we one cycle", lbl_we, 0);

        // Bad command, bytes refused in ERR, recovery and fresh load
        clear_log();
        send_byte(8'h3C);
        chk("bad err", err, 1);
        chk("bad in_ready", in_ready, 0);
        in_valid = 1'b1; in_data = 8'hA5;
        repeat (3) @(negedge clk);
        chk("bad still err", err, 1);
        in_valid = 1'b0;
        pulse_clr();
        chk("clr err", err, 0);
        chk("clr in_ready", in_ready, 1);
        build_prog(p1, 8'd0);
        send_all(0);
        idle(3);
        check_writes("after_err", p1, 1'b0);
        chk("after_err start", n_start, 1);
        chk("after_err loaded", prog_loaded, 1);

        // Zero-length program completes without writes
        clear_log();
        build_prog(p0, 8'd0);
        send_all(0);
        idle(3);
        chk("len0 writes", wa_q.size(), 0);
        chk("len0 start", n_start, 1);
        chk("len0 loaded", prog_loaded, 1);

        // Random gaps: same writes at same addresses
        clear_log();
        build_prog(p5, 8'd0);
        send_all(3);
        idle(3);
        check_writes("gaps", p5, 1'b0);
        chk("gaps start", n_start, 1);

        // Reset after data byte 2 of 5
        clear_log();
        tx = '{8'hA5, 8'h00, 8'h05, 8'h11, 8'h22};
        send_all(0);
        reset = 1'b1; in_valid = 1'b1; in_data = 8'h33;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("rst loaded", prog_loaded, 0);
        chk("rst in_ready", in_ready, 1);
        in_valid = 1'b1; in_data = 8'h33;
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h44;
        @(negedge clk);
        in_valid = 1'b0;
        idle(2);
        chk("rst writes", wa_q.size(), 2);
        chk("rst start", n_start, 0);
        chk("rst data byte in idle errs", err, 1);
        pulse_clr();

`ifdef INSTR_LOADER_CHKSUM_EN
        // Wrong checksum byte
        clear_log();
        build_prog(p3, 8'hDD);
        send_all(0);
        idle(2);
        chk("csum err", err, 1);
        chk("csum start", n_start, 0);
        chk("csum loaded", prog_loaded, 0);
        chk("csum writes kept", wa_q.size(), 3);
        pulse_clr();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
